// File: rtl/axi_rd_arbiter_if.sv
// AXI read channel (AR + R) bundle between the read arbiter and the memory side.
//   master : the arbiter. Drives the AR fields, arvalid and rready.
//   slave  : the memory or interconnect. Drives arready and the R fields.
interface axi_rd_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the instruction-cache and data-cache refill ports.
// Only one read is outstanding at a time. The data side wins arbitration unless the
// instruction side has waited through INST_STARVE_LIMIT consecutive data grants.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   inst_* / data_*      request side: req, uncached, addr in; addr_ok, beat_ok, data_ok, rdata out
//   axi                  AXI AR/R channel (master modport)
//
// state  | meaning
// S_IDLE | no transaction in flight; arbitrate and latch the winner's request
// S_AR   | arvalid high with stable address fields until arready
// S_R    | rready high; steer R beats to the owner until rlast
module axi_rd_arbiter #(
    parameter int LINE_WORDS        = 8,
    parameter int INST_STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_uncached,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_beat_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_uncached,
    input  logic [31:0] data_addr,
    output logic        data_addr_ok,
    output logic        data_beat_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    axi_rd_arbiter_if.master axi
);

    localparam int OFF_BITS = $clog2(LINE_WORDS) + 2;
    localparam int BEAT_W   = $clog2(LINE_WORDS) + 1;
    localparam int STREAK_W = $clog2(INST_STARVE_LIMIT + 1);

    localparam logic [31:0]         LINE_MASK  = ~((32'd1 << OFF_BITS) - 32'd1);
    localparam logic [7:0]          BURST_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(INST_STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         araddr_q, araddr_d;
    logic [7:0]          arlen_q, arlen_d;
    logic [3:0]          arid_q, arid_d;
    logic                owner_data_q, owner_data_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic                grant_data;
    logic                grant_inst;
    logic                sel_uncached;
    logic [31:0]         sel_addr;

    // rid and rresp carry nothing this block acts on.
    logic unused_axi;
    assign unused_axi = ^{axi.rid, axi.rresp};

    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arid_q       <= '0;
            owner_data_q <= 1'b0;
            streak_q     <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arid_q       <= arid_d;
            owner_data_q <= owner_data_d;
            streak_q     <= streak_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arid_d       = arid_q;
        owner_data_d = owner_data_q;
        streak_d     = streak_q;
        beat_cnt_d   = beat_cnt_q;

        grant_data   = 1'b0;
        grant_inst   = 1'b0;
        sel_uncached = 1'b0;
        sel_addr     = '0;

        axi.arvalid  = 1'b0;
        axi.rready   = 1'b0;
        inst_addr_ok = 1'b0;
        inst_beat_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_beat_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;

        case (state_q)
            S_IDLE: begin
                grant_data = data_req && !(inst_req && (streak_q == STREAK_MAX));
                grant_inst = inst_req && !grant_data;

                // The streak only measures how long a waiting inst request has been
                // passed over, so it restarts whenever inst is not waiting.
                if (!inst_req || grant_inst) begin
                    streak_d = '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + 1'b1;
                end

                if (grant_data || grant_inst) begin
                    sel_uncached = grant_data ? data_uncached : inst_uncached;
                    sel_addr     = grant_data ? data_addr : inst_addr;
                    araddr_d     = sel_uncached ? sel_addr : (sel_addr & LINE_MASK);
                    arlen_d      = sel_uncached ? 8'd0 : BURST_LEN;
                    arid_d       = grant_data ? 4'd1 : 4'd0;
                    owner_data_d = grant_data;
                    inst_addr_ok = grant_inst;
                    data_addr_ok = grant_data;
                    state_d      = S_AR;
                end
            end

            S_AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) begin
                    beat_cnt_d = '0;
                    state_d    = S_R;
                end
            end

            S_R: begin
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (owner_data_q) begin
                        data_beat_ok = 1'b1;
                        data_data_ok = axi.rlast;
                        data_rdata   = axi.rdata;
                    end else begin
                        inst_beat_ok = 1'b1;
                        inst_data_ok = axi.rlast;
                        inst_rdata   = axi.rdata;
                    end
                    if (axi.rlast) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The burst is closed by rlast alone; the beat count is only a consistency check
    // that the slave returned exactly arlen+1 beats.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_R) && axi.rvalid && axi.rlast) begin
            assert (8'(beat_cnt_q) == arlen_q);
        end
    end

endmodule
